// File: rtl/frame_scheduler_pkg.sv
// Shared types and constants for the per-frame update scheduler.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } sched_state_t;

  localparam int unsigned PH_INPUT   = 0;
  localparam int unsigned PH_PLAYER  = 1;
  localparam int unsigned PH_BULLET  = 2;
  localparam int unsigned PH_ALIEN   = 3;
  localparam int unsigned PH_COLLIDE = 4;

  localparam int unsigned DEFAULT_VC      = 1024;
  localparam int unsigned DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase watchdog: counts clocks while a phase runs, flags the limit.
module phase_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/frame_scheduler.sv
// Launches the per-frame update phases in vertical blanking via start/done handshakes.
//
// state    | meaning
// S_IDLE   | waiting for the end of the active frame
// S_SELECT | pick the lowest enabled phase at or above idx
// S_LAUNCH | one-cycle start pulse for phase idx, watchdog cleared
// S_WAIT   | waiting for done of phase idx or watchdog expiry
// S_FINISH | schedule complete, bump frame_count
import frame_sched_pkg::*;

module frame_scheduler #(
  parameter int unsigned VC        = DEFAULT_VC,
  parameter int unsigned NPH       = 5,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int unsigned ALIEN_DIV = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           display,
  input  logic [31:0]    Y,
  input  logic [NPH-1:0] phase_en,
  input  logic [NPH-1:0] phase_done,
  input  logic           clr_flags,
  output logic [NPH-1:0] phase_start,
  output logic [2:0]     cur_phase,
  output logic           busy,
  output logic [15:0]    frame_count,
  output logic           overrun,
  output logic           timeout
);

  sched_state_t   state, state_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [NPH-1:0] mask, run_mask;
  logic           display_d;
  logic           frame_end, frame_begin;
  logic           mask_ld, count_inc, set_ovr, set_to;
  logic           sel_found;
  logic [2:0]     sel_idx;
  logic           wd_expired;

  assign frame_end   = display_d & ~display & (Y == 32'(VC - 1));
  assign frame_begin = ~display_d & display & (Y == 32'd0);

  always_comb begin
    run_mask = phase_en;
    if ((frame_count % 16'(ALIEN_DIV)) != 16'd0) run_mask[PH_ALIEN] = 1'b0;
  end

  // Highest-to-lowest scan so the lowest qualifying bit wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int j = NPH - 1; j >= 0; j--) begin
      if (mask[j] && (j >= int'(idx))) begin
        sel_found = 1'b1;
        sel_idx   = 3'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_ld   = 1'b0;
    count_inc = 1'b0;
    set_ovr   = 1'b0;
    set_to    = 1'b0;
    if (state != S_IDLE && frame_begin) begin
      state_nxt = S_IDLE;
      set_ovr   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_end) begin
            state_nxt = S_SELECT;
            idx_nxt   = 3'(PH_INPUT);
            mask_ld   = 1'b1;
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            idx_nxt   = sel_idx;
            state_nxt = S_LAUNCH;
          end else begin
            state_nxt = S_FINISH;
          end
        end
        S_LAUNCH: state_nxt = S_WAIT;
        S_WAIT: begin
          if (phase_done[idx] || wd_expired) begin
            set_to    = ~phase_done[idx];
            idx_nxt   = idx + 3'd1;
            state_nxt = S_SELECT;
          end
        end
        S_FINISH: begin
          count_inc = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      mask        <= '0;
      display_d   <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      display_d   <= display;
      if (mask_ld)   mask <= run_mask;
      if (count_inc) frame_count <= frame_count + 16'd1;
      overrun     <= set_ovr | (overrun & ~clr_flags);
      timeout     <= set_to  | (timeout & ~clr_flags);
    end
  end

  phase_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == S_LAUNCH),
    .enable  (state == S_WAIT),
    .expired (wd_expired)
  );

  assign phase_start = (state == S_LAUNCH) ? (NPH'(1) << idx) : '0;
  assign cur_phase   = (state == S_LAUNCH || state == S_WAIT) ? idx : 3'd0;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: phase ordering, skipping, timeout, overrun, reset.
module tb_frame_scheduler;

  localparam int VC  = 1024;
  localparam int NPH = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           display;
  logic [31:0]    Y;
  logic [NPH-1:0] phase_en;
  logic [NPH-1:0] phase_done;
  logic           clr_flags;
  logic [NPH-1:0] phase_start;
  logic [2:0]     cur_phase;
  logic           busy;
  logic [15:0]    frame_count;
  logic           overrun;
  logic           timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NPH-1:0] stall    = '0;
  logic [NPH-1:0] force_dn = '0;
  int             done_at[NPH];
  int             st_idx[$];
  int             st_cyc[$];

  frame_scheduler #(.VC(VC), .NPH(NPH), .TIMEOUT(16), .ALIEN_DIV(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .display     (display),
    .Y           (Y),
    .phase_en    (phase_en),
    .phase_done  (phase_done),
    .clr_flags   (clr_flags),
    .phase_start (phase_start),
    .cur_phase   (cur_phase),
    .busy        (busy),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  function automatic int now();
    return int'($time / 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Logic-engine model: done pulse 3 cycles after each start unless stalled.
  initial begin
    for (int i = 0; i < NPH; i++) done_at[i] = -1;
    phase_done = '0;
    forever begin
      @(negedge clock);
      phase_done = force_dn;
      for (int i = 0; i < NPH; i++) if (done_at[i] == now()) phase_done[i] = 1'b1;
      for (int i = 0; i < NPH; i++) begin
        if (phase_start[i] === 1'b1) begin
          st_idx.push_back(i);
          st_cyc.push_back(now());
          if (!stall[i]) done_at[i] = now() + 3;
        end
      end
    end
  end

  task automatic to_cycle(input int c);
    while (now() < c) @(negedge clock);
  endtask

  task automatic frame_end_pulse(output int t0);
    st_idx.delete();
    st_cyc.delete();
    @(negedge clock);
    display = 1'b1;
    Y       = 32'(VC - 1);
    @(negedge clock);
    display = 1'b0;
    t0      = now();
    @(negedge clock);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 200 && busy; k++) @(negedge clock);
    check(tag, busy, 0);
  endtask

  task automatic pulse_clr();
    @(negedge clock);
    clr_flags = 1'b1;
    @(negedge clock);
    clr_flags = 1'b0;
  endtask

  int t0;
  int gap;

  initial begin
    reset     = 1'b0;
    display   = 1'b0;
    Y         = 32'd0;
    phase_en  = '0;
    clr_flags = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_start", phase_start, 0);
    check("rst_cur", cur_phase, 0);
    check("rst_fc", frame_count, 0);
    check("rst_flags", {overrun, timeout}, 0);
    @(negedge clock);
    reset = 1'b1;

    // all phases, frame_count 0: five starts spaced 5 cycles
    phase_en = 5'b11111;
    frame_end_pulse(t0);
    check("t1_busy", busy, 1);
    to_cycle(t0 + 7);
    check("t1_start1", phase_start, 5'b00010);
    to_cycle(t0 + 8);
    check("t1_cur", cur_phase, 1);
    wait_idle("t1_idle");
    check("t1_nstart", st_idx.size(), 5);
    for (int k = 0; k < 5 && k < st_idx.size(); k++) begin
      check($sformatf("t1_idx%0d", k), st_idx[k], k);
      check($sformatf("t1_cyc%0d", k), st_cyc[k] - t0, 2 + 5 * k);
    end
    check("t1_fc", frame_count, 1);

    // frame_count 1: alien phase skipped
    frame_end_pulse(t0);
    wait_idle("t2_idle");
    check("t2_nstart", st_idx.size(), 4);
    for (int k = 0; k < 4 && k < st_idx.size(); k++) begin
      check($sformatf("t2_idx%0d", k), st_idx[k], (k < 3) ? k : 4);
      check($sformatf("t2_cyc%0d", k), st_cyc[k] - t0, 2 + 5 * k);
    end
    check("t2_fc", frame_count, 2);

    // empty mask: SELECT then FINISH
    phase_en = 5'b00000;
    frame_end_pulse(t0);
    check("t3_busy", busy, 1);
    to_cycle(t0 + 3);
    check("t3_fc", frame_count, 3);
    check("t3_idle", busy, 0);
    check("t3_nstart", st_idx.size(), 0);

    // phase 2 never answers: watchdog forces advance to phase 4
    phase_en = 5'b10100;
    stall    = 5'b00100;
    frame_end_pulse(t0);
    wait_idle("t4_idle");
    check("t4_nstart", st_idx.size(), 2);
    if (st_idx.size() == 2) begin
      check("t4_idx0", st_idx[0], 2);
      check("t4_idx1", st_idx[1], 4);
      gap = st_cyc[1] - st_cyc[0];
      check("t4_gap", (gap >= 17 && gap <= 18), 1);
    end
    check("t4_timeout", timeout, 1);
    check("t4_fc", frame_count, 4);
    stall = '0;
    pulse_clr();
    check("t4_clr", timeout, 0);

    // phase 1 stalls into next frame: abort with overrun, clr in same cycle loses
    phase_en = 5'b00011;
    stall    = 5'b00010;
    frame_end_pulse(t0);
    to_cycle(t0 + 8);
    check("t5_cur", cur_phase, 1);
    display   = 1'b1;
    Y         = 32'd0;
    clr_flags = 1'b1;
    @(negedge clock);
    clr_flags = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_overrun", overrun, 1);
    check("t5_fc", frame_count, 4);
    check("t5_timeout", timeout, 0);
    stall    = '0;
    phase_en = 5'b00001;
    frame_end_pulse(t0);
    wait_idle("t5_idle2");
    check("t5_nstart2", st_idx.size(), 1);
    check("t5_fc2", frame_count, 5);
    check("t5_sticky", overrun, 1);
    pulse_clr();
    check("t5_clr", overrun, 0);

    // async reset while phase 4 waits
    phase_en = 5'b10000;
    stall    = 5'b10000;
    frame_end_pulse(t0);
    to_cycle(t0 + 3);
    check("t6_cur_pre", cur_phase, 4);
    check("t6_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_cur", cur_phase, 0);
    check("t6_start", phase_start, 0);
    check("t6_fc", frame_count, 0);
    check("t6_flags", {overrun, timeout}, 0);
    @(negedge clock);
    reset    = 1'b1;
    stall    = '0;
    st_idx.delete();
    st_cyc.delete();
    force_dn = 5'b11111;
    repeat (3) @(negedge clock);
    force_dn = '0;
    @(negedge clock);
    check("t6_ignore_busy", busy, 0);
    check("t6_ignore_start", st_idx.size(), 0);
    phase_en = 5'b00001;
    frame_end_pulse(t0);
    wait_idle("t6_idle");
    check("t6_nstart2", st_idx.size(), 1);
    check("t6_fc2", frame_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences per-frame game-logic updates for the 1280x1024 display pipeline. It watches the pixel timing generator's `display` and `Y` outputs, detects the end of each active frame, and launches a fixed series of update phases (input, player, bullets, aliens, collision) through start/done handshakes inside vertical blanking. It reports a frame counter, the active phase, and sticky overrun and timeout flags.

## Interface
- `VC`, 1024: active lines per frame; the last active line is `VC-1`.
- `NPH`, 5: number of phases; phase indices run 0..NPH-1.
- `TIMEOUT`, 4096: maximum clocks a phase may take before the block forces it to advance.
- `ALIEN_DIV`, 4: the alien phase (index 3) runs only when `frame_count % ALIEN_DIV == 0`.

- `clock`  in  1  pixel clock, the same clock that drives the timing generator.
- `reset`  in  1  asynchronous, active-low; the block is in reset while `reset==0`.
- `display`  in  1  active-video flag from the timing generator.
- `Y`  in  32  current active line from the timing generator.
- `phase_en`  in  NPH  per-phase enable mask, sampled at frame end.
- `phase_done`  in  NPH  per-phase completion pulse or level from the logic engines.
- `phase_start`  out  NPH  one-hot, single-cycle launch pulse.
- `cur_phase`  out  3  index of the running phase; 0 when idle.
- `busy`  out  1  high in any state other than IDLE.
- `frame_count`  out  16  count of completed schedules; wraps 0xFFFF->0.
- `overrun`  out  1  sticky: a new frame started while the block was busy.
- `timeout`  out  1  sticky: a phase hit the TIMEOUT limit.
- `clr_flags`  in  1  synchronous clear of `overrun` and `timeout`.

## Operation
- Reset values: state IDLE; `phase_start`=0, `cur_phase`=0, `busy`=0, `frame_count`=0, `overrun`=0, `timeout`=0, `display_d`=0.
- `display_d` is `display` registered by one clock.
- `frame_end` = `display_d & ~display & (Y==VC-1)`.
- `frame_begin` = `~display_d & display & (Y==0)`.
- States: IDLE, SELECT, LAUNCH, WAIT, FINISH.
- IDLE: on `frame_end`, latch the run mask and go to SELECT with index i=0.
  - Run mask = `phase_en`, with bit 3 cleared when `frame_count % ALIEN_DIV != 0`.
- SELECT: find the lowest set mask bit at or above i.
  - If found, set i to it and go to LAUNCH.
  - If none, go to FINISH.
  - Skipped phases cost no cycles beyond this single SELECT cycle.
- LAUNCH: drive `phase_start[i]`=1 for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT: increment the watchdog every cycle.
  - `phase_done[i]` high: go to SELECT with i=i+1.
  - Watchdog reaches TIMEOUT-1 with no done: set `timeout`, then behave as if done.
  - `phase_done` bits other than i are ignored.
- FINISH: increment `frame_count`, go to IDLE.
- `cur_phase` = i in LAUNCH and WAIT; 0 otherwise.
- Overrun: `frame_begin` while not IDLE sets `overrun` and aborts to IDLE.
  - No FINISH, no `frame_count` increment.
  - A phase that was already launched is not recalled.
- `clr_flags` and a flag set in the same cycle: the set wins.
- A `frame_end` in any state other than IDLE is ignored; this only occurs after an abort.

## Timing
- `frame_end` is asserted in the clock where `display` is first low (cycle N).
- The IDLE->SELECT transition is registered at the end of cycle N.
- `phase_start` of the first enabled phase is high in cycle N+2.
- `phase_done[i]` is accepted from the cycle after `phase_start[i]`.
  - A done asserted in the same cycle as the start pulse is ignored.
- Done accepted in cycle M: the next start is at M+2 (SELECT, then LAUNCH).
- After the last done in cycle M, `frame_count` updates in cycle M+2, with `busy` low from M+3.
- Vertical blanking is 42 lines of 1688 clocks. The schedule must complete within that window or `overrun` fires.

## Structure
- Package `frame_sched_pkg`:
  - state enum;
  - phase index constants `PH_INPUT`=0, `PH_PLAYER`=1, `PH_BULLET`=2, `PH_ALIEN`=3, `PH_COLLIDE`=4;
  - default `VC` and `TIMEOUT`.
- Sub-module `phase_watchdog`:
  - inputs: clear, enable;
  - output: `expired`;
  - counter width `$clog2(TIMEOUT)`.
- All other logic lives in `frame_scheduler`.

## Test plan
- All phases enabled, `frame_count`=0, each done returned 3 cycles after its start -> starts on indices 0,1,2,3,4 in order; `frame_count`=1; `busy` low afterwards.
- `frame_count`=1, `phase_en`=5'b11111 -> phase 3 is skipped: starts on 0,1,2,4 only.
- `phase_en`=0 -> `frame_count` increments 2 cycles after `frame_end`; no `phase_start` pulses.
- Phase 2 never returns done, TIMEOUT=16 -> `timeout`=1; phase 4 starts 17-18 cycles after the phase-2 start.
- Phase 1 stalls until the next frame's `display` rises with Y=0 -> `overrun`=1; `busy`=0; `frame_count` unchanged; the following frame schedules normally.
- `reset` driven low mid-WAIT, without a clock edge -> all outputs return to their reset values immediately; `phase_done` is ignored until a new `frame_end`.
